// File: rtl/sy_plic_tgt_arb.sv
// sy_plic_tgt_arb: per-target PLIC gateway, sequential max-priority sweep and claim/complete handling.
module sy_plic_tgt_arb #(
    parameter int SOURCE_NUM = 30,
    parameter int MAX_PRI    = 7,
    parameter int PRIO_W     = $clog2(MAX_PRI + 1),
    parameter int ID_W       = $clog2(SOURCE_NUM + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [SOURCE_NUM-1:0]        irq_sources_i,
    input  logic [SOURCE_NUM*PRIO_W-1:0] prio_i,
    input  logic [SOURCE_NUM-1:0]        ie_i,
    input  logic [PRIO_W-1:0]            threshold_i,
    input  logic                         claim_valid_i,
    output logic                         claim_ready_o,
    output logic                         claim_rsp_valid_o,
    output logic [ID_W-1:0]              claim_id_o,
    input  logic                         complete_valid_i,
    input  logic [ID_W-1:0]              complete_id_i,
    output logic                         irq_o,
    output logic [SOURCE_NUM-1:0]        pending_o
);
    typedef enum logic {SCAN, RSP} state_t;
    state_t state_q, state_d;
    logic [SOURCE_NUM-1:0] pending_q, inflight_q, claim_mask, cpl_mask;
    logic [ID_W-1:0]       idx_q, best_id_q, max_id_q, claim_id_q;
    logic [ID_W-1:0]       idx_id, best_id_d, sel_idx, rsp_id, cpl_idx;
    logic [PRIO_W-1:0]     best_pri_q, max_pri_q, idx_pri, best_pri_d;
    logic                  cand, last, rsp;

    assign rsp        = state_q == RSP;
    assign idx_pri    = prio_i[idx_q*PRIO_W +: PRIO_W];
    assign idx_id     = idx_q + ID_W'(1);
    // strict compare keeps the lowest ID on priority ties
    assign cand       = pending_q[idx_q] & ie_i[idx_q] & (idx_pri != '0) & (idx_pri > best_pri_q);
    assign best_id_d  = cand ? idx_id : best_id_q;
    assign best_pri_d = cand ? idx_pri : best_pri_q;
    assign last       = idx_q == ID_W'(SOURCE_NUM - 1);

    // the committed winner may have been claimed away or disabled since the sweep saw it
    assign sel_idx    = max_id_q - ID_W'(1);
    assign rsp_id     = (max_id_q != '0 && pending_q[sel_idx] && ie_i[sel_idx]) ? max_id_q : '0;
    assign claim_mask = (rsp && rsp_id != '0) ? SOURCE_NUM'(1) << (rsp_id - ID_W'(1)) : '0;

    assign cpl_idx    = complete_id_i - ID_W'(1);
    assign cpl_mask   = (complete_valid_i && complete_id_i != '0 && complete_id_i <= ID_W'(SOURCE_NUM))
                        ? (SOURCE_NUM'(1) << cpl_idx) & inflight_q : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            inflight_q <= '0;
        end else begin
            pending_q  <= (pending_q | (irq_sources_i & ~inflight_q)) & ~claim_mask;
            inflight_q <= (inflight_q & ~cpl_mask) | claim_mask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || rsp) begin
            idx_q      <= '0;
            best_id_q  <= '0;
            best_pri_q <= '0;
            max_id_q   <= '0;
            max_pri_q  <= '0;
        end else begin
            idx_q      <= last ? '0 : idx_q + ID_W'(1);
            best_id_q  <= last ? '0 : best_id_d;
            best_pri_q <= last ? '0 : best_pri_d;
            max_id_q   <= last ? best_id_d : max_id_q;
            max_pri_q  <= last ? best_pri_d : max_pri_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SCAN;
            claim_id_q <= '0;
        end else begin
            state_q    <= state_d;
            claim_id_q <= rsp ? rsp_id : claim_id_q;
        end
    end

    always_comb begin
        state_d = (!rsp && claim_valid_i) ? RSP : SCAN;
    end

    always_comb begin
        claim_ready_o     = !rsp;
        claim_rsp_valid_o = rsp;
        claim_id_o        = rsp ? rsp_id : claim_id_q;
    end

    assign irq_o     = max_pri_q > threshold_i;
    assign pending_o = pending_q;
endmodule

// File: tb/tb_sy_plic_tgt_arb.sv
// tb_sy_plic_tgt_arb: directed checks of gateway, sweep, threshold and claim/complete behaviour.
module tb_sy_plic_tgt_arb;
    localparam int N = 30;
    localparam int PW = 3;
    localparam int IW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  irq_sources_i;
    logic [N*PW-1:0] prio_i;
    logic [N-1:0]  ie_i;
    logic [PW-1:0] threshold_i;
    logic          claim_valid_i;
    logic          claim_ready_o;
    logic          claim_rsp_valid_o;
    logic [IW-1:0] claim_id_o;
    logic          complete_valid_i;
    logic [IW-1:0] complete_id_i;
    logic          irq_o;
    logic [N-1:0]  pending_o;

    int total = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    sy_plic_tgt_arb dut (
        .clk_i(clk_i), .rst_i(rst_i), .irq_sources_i(irq_sources_i), .prio_i(prio_i),
        .ie_i(ie_i), .threshold_i(threshold_i), .claim_valid_i(claim_valid_i),
        .claim_ready_o(claim_ready_o), .claim_rsp_valid_o(claim_rsp_valid_o),
        .claim_id_o(claim_id_o), .complete_valid_i(complete_valid_i),
        .complete_id_i(complete_id_i), .irq_o(irq_o), .pending_o(pending_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_prio(input int id, input int p);
        logic [31:0] v;
        v = p;
        prio_i[(id-1)*PW +: PW] = v[PW-1:0];
    endtask

    // two full sweeps guarantee the committed max reflects the current state
    task automatic settle();
        step(2*N + 2);
    endtask

    task automatic claim(input string tag, input int exp);
        chk({tag, "_rdy"}, claim_ready_o, 1);
        claim_valid_i = 1'b1;
        step();
        claim_valid_i = 1'b0;
        chk({tag, "_rspv"}, claim_rsp_valid_o, 1);
        chk({tag, "_id"}, claim_id_o, exp);
        chk({tag, "_busy"}, claim_ready_o, 0);
        step();
        chk({tag, "_rspv_off"}, claim_rsp_valid_o, 0);
        chk({tag, "_hold"}, claim_id_o, exp);
    endtask

    task automatic cpl(input int id);
        logic [31:0] v;
        v = id;
        complete_valid_i = 1'b1;
        complete_id_i = v[IW-1:0];
        step();
        complete_valid_i = 1'b0;
        complete_id_i = '0;
    endtask

    task automatic wait_irq(input string tag, input int budget);
        int k = 0;
        while (!irq_o && k < budget) begin
            step();
            k++;
        end
        chk(tag, irq_o, 1);
    endtask

    initial begin
        rst_i = 1'b1;
        irq_sources_i = '0;
        prio_i = '0;
        ie_i = '0;
        threshold_i = '0;
        claim_valid_i = 1'b0;
        complete_valid_i = 1'b0;
        complete_id_i = '0;
        step(2);
        rst_i = 1'b0;
        chk("rst_irq", irq_o, 0);
        chk("rst_rdy", claim_ready_o, 1);
        chk("rst_rspv", claim_rsp_valid_o, 0);
        chk("rst_id", claim_id_o, 0);
        chk("rst_pend", pending_o, 0);
        claim("idle", 0);
        chk("idle_pend", pending_o, 0);

        // single source ID4
        ie_i = '1;
        set_prio(4, 5);
        irq_sources_i[3] = 1'b1;
        wait_irq("id4_irq", 2*N + 1);
        claim("id4", 4);
        chk("id4_pend_clr", pending_o[3], 0);
        chk("id4_irq_off", irq_o, 0);
        settle();
        chk("id4_no_repend", pending_o[3], 0);
        chk("id4_no_irq", irq_o, 0);
        cpl(4);
        step();
        chk("id4_repend", pending_o[3], 1);

        // bogus completions leave ID4 inflight
        settle();
        claim("id4b", 4);
        cpl(0);
        cpl(9);
        cpl(31);
        settle();
        chk("bogus_pend", pending_o[3], 0);
        chk("bogus_irq", irq_o, 0);
        cpl(4);
        step();
        chk("real_cpl_repend", pending_o[3], 1);
        irq_sources_i[3] = 1'b0;

        // disable after commit: claim returns 0 and pending survives
        settle();
        chk("pre_dis_irq", irq_o, 1);
        ie_i[3] = 1'b0;
        claim("dis", 0);
        chk("dis_pend", pending_o[3], 1);
        chk("dis_irq", irq_o, 0);
        ie_i[3] = 1'b1;
        settle();
        claim("id4c", 4);
        cpl(4);
        step();
        chk("id4c_pend", pending_o[3], 0);

        // tie between IDs 2 and 7 at prio 6
        set_prio(2, 6);
        set_prio(7, 6);
        irq_sources_i[1] = 1'b1;
        irq_sources_i[6] = 1'b1;
        step();
        irq_sources_i[1] = 1'b0;
        irq_sources_i[6] = 1'b0;
        settle();
        claim("tie1", 2);
        settle();
        claim("tie2", 7);
        settle();
        chk("tie_irq_off", irq_o, 0);
        cpl(2);
        cpl(7);

        // threshold is a strict compare
        set_prio(5, 3);
        irq_sources_i[4] = 1'b1;
        step();
        irq_sources_i[4] = 1'b0;
        threshold_i = 3'd3;
        settle();
        chk("thr_eq", irq_o, 0);
        threshold_i = 3'd2;
        #1;
        chk("thr_below", irq_o, 1);
        claim("thr", 5);
        cpl(5);
        set_prio(5, 0);
        threshold_i = 3'd0;
        irq_sources_i[4] = 1'b1;
        step();
        irq_sources_i[4] = 1'b0;
        settle();
        chk("prio0_irq", irq_o, 0);
        chk("prio0_pend", pending_o[4], 1);
        claim("prio0", 0);
        chk("prio0_pend_kept", pending_o[4], 1);

        // reset while the response is being presented
        set_prio(5, 3);
        settle();
        chk("pre_rst_irq", irq_o, 1);
        claim_valid_i = 1'b1;
        step();
        claim_valid_i = 1'b0;
        chk("mid_rspv", claim_rsp_valid_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mid_rst_rspv", claim_rsp_valid_o, 0);
        chk("mid_rst_id", claim_id_o, 0);
        chk("mid_rst_pend", pending_o, 0);
        chk("mid_rst_irq", irq_o, 0);
        chk("mid_rst_rdy", claim_ready_o, 1);
        settle();
        chk("post_rst_irq", irq_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sy_plic_tgt_arb.md
Name: sy_plic_tgt_arb

Overview:
Per-target interrupt gateway and claim/complete scheduler for the platform-level interrupt controller (PLIC) subsystem. It latches level-sensitive sources into pending bits and runs a sequential one-source-per-cycle sweep to find the highest-priority enabled pending source. It drives the target's interrupt line and services claim/complete handshakes from the register front-end. One instance exists per hart context; the register-bank block supplies the priority, enable and threshold values.

Parameters:
SOURCE_NUM, 30, number of interrupt sources; irq_sources_i[i] is interrupt ID i+1, and ID 0 means "none".
MAX_PRI, 7, highest priority value; priority 0 means "never interrupt".
PRIO_W, $clog2(MAX_PRI+1) = 3, width of a priority or threshold field.
ID_W, $clog2(SOURCE_NUM+1) = 5, width of an interrupt ID.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset; synchronous, active-high.
irq_sources_i  in  SOURCE_NUM  level interrupt sources, synchronous to clk_i.
prio_i  in  SOURCE_NUM*PRIO_W  flat priorities; bits [i*PRIO_W +: PRIO_W] belong to ID i+1.
ie_i  in  SOURCE_NUM  per-source enable for this target.
threshold_i  in  PRIO_W  target priority threshold.
claim_valid_i  in  1  claim request (register read of claim/complete).
claim_ready_o  out  1  claim accepted when valid & ready.
claim_rsp_valid_o  out  1  one-cycle strobe; claim_id_o is valid.
claim_id_o  out  ID_W  claimed ID, 0 if none.
complete_valid_i  in  1  completion strobe.
complete_id_i  in  ID_W  completed ID.
irq_o  out  1  target interrupt request.
pending_o  out  SOURCE_NUM  pending bits, for readback.

Behaviour:
- Reset (rst_i=1 at clk edge):
  - pending, inflight, sweep index, running best, committed max_id_q/max_pri_q and claim response regs all go to 0.
  - FSM goes to SCAN.
  - Outputs after reset: irq_o=0, claim_rsp_valid_o=0, claim_id_o=0, pending_o=0, claim_ready_o=1.
  - Reset mid-claim: the response is dropped.
- Gateway, per source i:
  - pending[i] is set when irq_sources_i[i]=1 and pending[i]=0 and inflight[i]=0.
  - pending[i] is cleared only by a claim of ID i+1.
  - inflight[i] is set by that claim and cleared by a matching complete.
  - A held-high source therefore re-pends only after completion.
  - If set and claim-clear coincide, the clear wins.
- Sweep:
  - Index idx runs 0..SOURCE_NUM-1, advancing one per cycle and wrapping.
  - Candidate condition: pending[idx] & ie_i[idx] & prio>0.
  - Running best updates only when prio > best_pri (strict compare), so the lowest ID wins ties.
  - At idx=SOURCE_NUM-1, max_id_q/max_pri_q are committed (including that cycle's candidate), the running best is cleared and idx wraps to 0.
  - Changes to prio_i/ie_i take effect when the index is next visited.
  - Worst-case latency from a source assertion to irq_o: 2*SOURCE_NUM+1 cycles.
- irq_o = (max_pri_q > threshold_i). This is combinational from registers plus threshold_i; it is a strict compare, so equal-to-threshold does not interrupt.
- Claim FSM, states SCAN and RSP:
  - claim_ready_o = (state==SCAN).
  - In SCAN, claim_valid_i=1 moves to RSP.
  - In RSP, claim_rsp_valid_o=1 for exactly one cycle, then the FSM returns to SCAN.
  - claim_id_o = max_id_q if max_id_q!=0 and that source is still pending & enabled; otherwise 0. The claim ignores threshold.
  - On the RSP cycle, for a nonzero ID: clear its pending bit and set its inflight bit. In all cases: zero max_id_q/max_pri_q, reset idx to 0 and clear the running best (forced fresh sweep).
  - Claim latency is 1 cycle; at most one claim every 2 cycles.
  - claim_id_o holds its value until the next response.
- Complete:
  - Accepted in any cycle.
  - If 1 <= complete_id_i <= SOURCE_NUM and that ID's inflight bit is set, the inflight bit is cleared.
  - Otherwise the completion is ignored, with no error.
  - A complete for an ID being claimed in the same cycle is ignored, because that ID is not yet inflight.
- Arithmetic: ID = index+1, computed in ID_W bits; all priority compares are unsigned PRIO_W.

Test Plan:
- Reset, then claim with all sources low -> irq_o=0, claim_ready_o=1, claim_id_o=0 one cycle after the claim, pending_o=0.
- irq_sources_i[3]=1, prio(ID4)=5, ie=1, threshold=0 -> irq_o=1 within 61 cycles. Claim -> claim_id_o=4, pending_o[3]=0, irq_o=0. Source held high -> no re-pend. complete_id_i=4 -> pending_o[3]=1 on the next cycle.
- IDs 2 and 7 both prio 6 and enabled -> first claim returns 2; after the next full sweep a second claim returns 7.
- ID5 prio 3: threshold=3 -> irq_o=0; threshold=2 -> irq_o=1. With prio 0 and threshold 0 -> irq_o stays 0.
- Claim ID4, then complete IDs 0, 9 (not inflight) and 31 -> inflight for ID4 unchanged, source does not re-pend. Then complete 4 -> re-pend.
- After ID4 is committed as max, drop ie_i[3] and claim before the next commit -> claim_id_o=0 and pending_o[3] stays 1. Assert rst_i during RSP -> claim_rsp_valid_o=0 next cycle and all state cleared.
